// File: rtl/bound_flasher_monitor.sv
// Watches a 16-LED flasher bar and checks that its sequence is legal: six phases, direction changes at the phase limits, and flick kickbacks.
// Latency: 1 cycle. The LED value sampled at edge k sets every output after edge k.
// Backpressure: none; LED is sampled on every edge. Optional error counter enabled by BOUND_FLASHER_MONITOR_ERR_CNT_EN.
module bound_flasher_monitor #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      LED,
  output logic [4:0]       led_count,
  output logic [1:0]       mon_state,
  output logic [2:0]       mon_phase,
  output logic             flick_seen,
  output logic             seq_done,
  output logic             code_err,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  phase_q, phase_d;
  logic        flick_q, flick_d;
  logic        done_q, done_d;
  logic        code_err_q, code_err_d;
  logic        step_err_q, step_err_d;

  logic [16:0]       led_inc;
  logic              code_ok;
  logic [4:0]        n_dec;
  logic signed [5:0] delta;
  logic              is_up;
  logic              is_dn;
  logic [4:0]        lim;

  // Turning-point count for each phase: the maximum for UP phases, the minimum for DOWN phases.
  function automatic logic [4:0] phase_limit(input logic [2:0] ph);
    case (ph)
      3'd0:    phase_limit = 5'd16;
      3'd1:    phase_limit = 5'd6;
      3'd2:    phase_limit = 5'd11;
      3'd3:    phase_limit = 5'd0;
      3'd4:    phase_limit = 5'd6;
      default: phase_limit = 5'd0;
    endcase
  endfunction

  // Decode the bar. A thermometer code plus one is a power of two, so the AND of the two is zero.
  always_comb begin
    led_inc = {1'b0, LED} + 17'd1;
    code_ok = (({1'b0, LED} & led_inc) == 17'd0);
    n_dec   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n_dec = n_dec + {4'd0, LED[i]};
    end
    delta = $signed({1'b0, n_dec}) - $signed({1'b0, cnt_q});
    is_up = (delta == 6'sd1);
    is_dn = (delta == -6'sd1);
    lim   = phase_limit(phase_q);
  end

  // Next-state tracker. Any illegal step drops the tracker to IDLE/phase 0, so it has to resynchronise from count 0.
  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    phase_d    = phase_q;
    flick_d    = 1'b0;
    done_d     = 1'b0;
    code_err_d = 1'b0;
    step_err_d = 1'b0;
    if (!code_ok) begin
      code_err_d = 1'b1;
    end else begin
      cnt_d = n_dec;
      if (delta == 6'sd0) begin
        // The flasher dwells at its turning points; nothing to track.
      end else if (!is_up && !is_dn) begin
        step_err_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_up && (cnt_q == 5'd0)) begin
              state_d = ST_UP;
              phase_d = 3'd0;
            end else begin
              step_err_d = 1'b1;
            end
          end
          ST_UP: begin
            if (is_up) begin
              if (cnt_q >= lim) step_err_d = 1'b1;
            end else if (cnt_q == lim) begin
              state_d = ST_DOWN;
              phase_d = phase_q + 3'd1;
            end else begin
              step_err_d = 1'b1;
            end
          end
          ST_DOWN: begin
            if (is_dn) begin
              if (cnt_q <= lim) begin
                step_err_d = 1'b1;
              end else if ((phase_q == 3'd5) && (n_dec == 5'd0)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                phase_d = 3'd0;
              end
            end else if ((cnt_q == lim) && ((phase_q == 3'd1) || (phase_q == 3'd3))) begin
              // A turn at the phase minimum is the normal sequence; it wins over the flick check.
              state_d = ST_UP;
              phase_d = phase_q + 3'd1;
            end else if ((cnt_q == 5'd0) || (cnt_q == 5'd6)) begin
              flick_d = 1'b1;
              state_d = ST_UP;
              phase_d = phase_q - 3'd1;
            end else begin
              step_err_d = 1'b1;
            end
          end
          default: step_err_d = 1'b1;
        endcase
      end
      if (step_err_d) begin
        state_d = ST_IDLE;
        phase_d = 3'd0;
      end
    end
  end

  // Tracker and pulse registers. Reset takes priority over the LED sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      phase_q    <= 3'd0;
      flick_q    <= 1'b0;
      done_q     <= 1'b0;
      code_err_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      flick_q    <= flick_d;
      done_q     <= done_d;
      code_err_q <= code_err_d;
      step_err_q <= step_err_d;
    end
  end

  assign led_count  = cnt_q;
  assign mon_state  = state_q;
  assign mon_phase  = phase_q;
  assign flick_seen = flick_q;
  assign seq_done   = done_q;
  assign code_err   = code_err_q;
  assign step_err   = step_err_q;

`ifdef BOUND_FLASHER_MONITOR_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error count. It holds at all-ones, and only reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((code_err_d || step_err_d) && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Testbench for bound_flasher_monitor: a table of full-sequence vectors, then hand-written corner cases.
// Expected outputs are queued when LED is driven, then popped and compared 1 time unit after the sampling edge.
// The err_cnt expectation follows BOUND_FLASHER_MONITOR_ERR_CNT_EN (saturating counter when defined, 0 otherwise).
module tb_bound_flasher_monitor;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DN   = 2'b10;
  // Pulse flags, packed as {flick, done, code_err, step_err}.
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_FLICK = 4'b1000;
  localparam logic [3:0] F_DONE  = 4'b0100;
  localparam logic [3:0] F_CODE  = 4'b0010;
  localparam logic [3:0] F_STEP  = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] LED;
  logic [4:0]  led_count;
  logic [1:0]  mon_state;
  logic [2:0]  mon_phase;
  logic        flick_seen, seq_done, code_err, step_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  bound_flasher_monitor #(.ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .LED        (LED),
    .led_count  (led_count),
    .mon_state  (mon_state),
    .mon_phase  (mon_phase),
    .flick_seen (flick_seen),
    .seq_done   (seq_done),
    .code_err   (code_err),
    .step_err   (step_err),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic [4:0] cnt;
    logic [1:0] st;
    logic [2:0] ph;
    logic [3:0] flags;
    logic [7:0] err;
  } exp_t;

  typedef struct packed {
    logic [15:0] led;
    logic [4:0]  cnt;
    logic [1:0]  st;
    logic [2:0]  ph;
    logic [3:0]  flags;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       tbl[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_err = 8'd0;

  function automatic logic [15:0] thermo(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  function automatic void add(input logic [15:0] led, input int c, input logic [1:0] s,
                              input int p, input logic [3:0] f);
    vec_t v;
    v.led   = led;
    v.cnt   = 5'(c);
    v.st    = s;
    v.ph    = 3'(p);
    v.flags = f;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm);
    exp_t e, a;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      a = {led_count, mon_state, mon_phase, flick_seen, seq_done, code_err, step_err, err_cnt};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got cnt=%0d st=%0d ph=%0d flags=%b err=%0d, expected cnt=%0d st=%0d ph=%0d flags=%b err=%0d",
                 nm, a.cnt, a.st, a.ph, a.flags, a.err, e.cnt, e.st, e.ph, e.flags, e.err);
      end
    end
  endtask

  task automatic drive(input logic [15:0] led, input int c, input logic [1:0] s,
                       input int p, input logic [3:0] f, input string nm);
    exp_t e;
    @(negedge clk);
    LED = led;
`ifdef BOUND_FLASHER_MONITOR_ERR_CNT_EN
    if ((f[1] || f[0]) && (exp_err != 8'hFF)) exp_err = exp_err + 8'd1;
`endif
    e = {5'(c), s, 3'(p), f, exp_err};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic do_reset(input logic [15:0] led, input string nm);
    @(negedge clk);
    reset   = 1'b1;
    LED     = led;
    exp_err = 8'd0;
    sb_q.push_back('0);
    @(posedge clk);
    #1;
    check(nm);
    reset = 1'b0;
  endtask

  // Brings the monitor to DOWN, phase 1, at count `stop`.
  task automatic to_phase1(input int stop);
    do_reset(16'h0000, "reset");
    for (int n = 1; n <= 16; n++) drive(thermo(n), n, UP, 0, F_NONE, "pre_up0");
    for (int n = 15; n >= stop; n--) drive(thermo(n), n, DN, 1, F_NONE, "pre_dn1");
  endtask

  initial begin
    reset = 1'b1;
    LED   = 16'h0000;

    // Full six-phase sequence vectors.
    for (int n = 1; n <= 16; n++) add(thermo(n), n, UP, 0, F_NONE);
    add(thermo(16), 16, UP, 0, F_NONE);
    for (int n = 15; n >= 6; n--) add(thermo(n), n, DN, 1, F_NONE);
    for (int n = 7; n <= 11; n++) add(thermo(n), n, UP, 2, F_NONE);
    for (int n = 10; n >= 0; n--) add(thermo(n), n, DN, 3, F_NONE);
    for (int n = 1; n <= 6; n++) add(thermo(n), n, UP, 4, F_NONE);
    for (int n = 5; n >= 1; n--) add(thermo(n), n, DN, 5, F_NONE);
    add(16'h0000, 0, IDLE, 0, F_DONE);
    add(16'h0000, 0, IDLE, 0, F_NONE);
    add(16'h0001, 1, UP, 0, F_NONE);

    do_reset(16'hFFFF, "reset_state");
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].led, int'(tbl[i].cnt), tbl[i].st, int'(tbl[i].ph), tbl[i].flags, "seq_table");
    end

    // Flick back from phase 3 at count 6.
    to_phase1(6);
    for (int n = 7; n <= 11; n++) drive(thermo(n), n, UP, 2, F_NONE, "f_up2");
    for (int n = 10; n >= 6; n--) drive(thermo(n), n, DN, 3, F_NONE, "f_dn3");
    drive(16'h007F, 7, UP, 2, F_FLICK, "flick_ph3");
    drive(16'h00FF, 8, UP, 2, F_NONE, "after_flick");

    // Phase 1 at count 6 is a natural turn, not a flick.
    to_phase1(6);
    drive(16'h007F, 7, UP, 2, F_NONE, "natural_turn_ph1");

    // DOWN +1 away from the limit and away from 0/6 is illegal.
    to_phase1(10);
    drive(thermo(11), 11, IDLE, 0, F_STEP, "dn_bad_up");

    // UP -1 below the maximum is illegal.
    do_reset(16'h0000, "reset");
    for (int n = 1; n <= 3; n++) drive(thermo(n), n, UP, 0, F_NONE, "up0");
    drive(thermo(2), 2, IDLE, 0, F_STEP, "up_bad_dn");

    // Invalid code, then multi-step jumps and illegal moves out of IDLE.
    do_reset(16'h0000, "reset");
    for (int n = 1; n <= 4; n++) drive(thermo(n), n, UP, 0, F_NONE, "up0");
    drive(16'h0005, 4, UP, 0, F_CODE, "code_err_hold");
    drive(16'h003F, 6, IDLE, 0, F_STEP, "jump_4_to_6");
    drive(16'h007F, 7, IDLE, 0, F_STEP, "idle_up_nonzero");
    drive(16'h003F, 6, IDLE, 0, F_STEP, "idle_down");
    drive(16'h0000, 0, IDLE, 0, F_STEP, "jump_6_to_0");
    drive(16'h0001, 1, UP, 0, F_NONE, "resync_up");

    // Flood of invalid codes: the counter saturates when enabled.
    do_reset(16'h0000, "reset");
    for (int i = 0; i < 300; i++) drive(16'h0005, 0, IDLE, 0, F_CODE, "code_flood");
    drive(16'h8000, 0, IDLE, 0, F_CODE, "code_msb_only");

    // A reset in the middle of tracking overrides the LED sample and clears everything.
    for (int n = 1; n <= 5; n++) drive(thermo(n), n, UP, 0, F_NONE, "pre_reset_up");
    do_reset(thermo(6), "reset_override");
    drive(thermo(1), 1, UP, 0, F_NONE, "post_reset_first");
    do_reset(thermo(9), "reset_override2");
    drive(thermo(2), 2, IDLE, 0, F_STEP, "post_reset_jump");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
